u_lsu_store_buffer: RTL and testbench

//  Posted-store queue between the LSU store data extensor and data memory. Accepts line-aligned

---
 rtl/u_lsu_store_buffer_pkg.sv | 31 +++
 rtl/u_lsu_store_buffer_mem.sv | 90 +++++++++
 rtl/u_lsu_store_buffer.sv | 163 ++++++++++++++++
 tb/tb_u_lsu_store_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_lsu_store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// u_lsu_store_buffer_pkg
// Shared LSU definitions for the posted-store buffer:
//   `DATA_MEM_WIDTH      data memory line width in bits (128)
//   `DATA_MEM_WIDTH_BIT  data memory byte-address width
//   LINE_OFFSET          byte-offset bits inside a line (line addr = addr >> 4)
//   sb_state_t           drain FSM encodings (SB_IDLE, SB_ISSUE)
// Optional feature macro used by the buffer files: STORE_BUF_MERGE_EN.
// ---------------------------------------------------------------------------
`ifndef DATA_MEM_WIDTH
`define DATA_MEM_WIDTH 128
`endif
`ifndef DATA_MEM_WIDTH_BIT
`define DATA_MEM_WIDTH_BIT 16
`endif

package u_lsu_store_buffer_pkg;

  localparam int LINE_OFFSET = 4;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_ISSUE = 1'b1
  } sb_state_t;

  // Width of a line address for a given byte-address width.
  function automatic int sb_line_w(input int addr_w);
    return addr_w - LINE_OFFSET;
  endfunction

endpackage

// File: rtl/u_lsu_store_buffer_mem.sv
// ---------------------------------------------------------------------------
// u_lsu_store_buffer_mem
// DEPTH-entry register file holding {line address, data, write mask, valid}
// for the store buffer.
//   clk, rst            clock, asynchronous active-high reset (valid bits only)
//   wr_en/wr_idx/...    write port; sets valid on the addressed entry
//   wr_merge, st_line,  (STORE_BUF_MERGE_EN only) byte-merge write mode and a
//   st_match            per-entry line compare against the incoming store
//   clr_en/clr_idx      clears the valid bit of a drained entry
//   rd_idx, head_*      combinational read port for the head entry
//   ld_line, ld_match   per-entry compare of valid lines against a load line
// ---------------------------------------------------------------------------
module u_lsu_store_buffer_mem
  import u_lsu_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int LINE_W = 12,
  parameter int DATA_W = `DATA_MEM_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_wen,
`ifdef STORE_BUF_MERGE_EN
  input  logic              wr_merge,
  input  logic [LINE_W-1:0] st_line,
  output logic [DEPTH-1:0]  st_match,
`endif
  input  logic              clr_en,
  input  logic [PTR_W-1:0]  clr_idx,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] head_line,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] head_wen,
  input  logic [LINE_W-1:0] ld_line,
  output logic [DEPTH-1:0]  ld_match
);

  logic [LINE_W-1:0] line_reg [DEPTH];
  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [DATA_W-1:0] wen_reg  [DEPTH];
  logic [DEPTH-1:0]  valid_reg;

  // Only the valid bits need reset; payload is qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      if (clr_en) valid_reg[clr_idx] <= 1'b0;
      if (wr_en)  valid_reg[wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_reg[wr_idx] <= wr_line;
`ifdef STORE_BUF_MERGE_EN
      if (wr_merge) begin
        // Newer bytes overwrite older ones only where the new mask is set.
        data_reg[wr_idx] <= (data_reg[wr_idx] & ~wr_wen) | (wr_data & wr_wen);
        wen_reg[wr_idx]  <= wen_reg[wr_idx] | wr_wen;
      end else begin
        data_reg[wr_idx] <= wr_data;
        wen_reg[wr_idx]  <= wr_wen;
      end
`else
      data_reg[wr_idx] <= wr_data;
      wen_reg[wr_idx]  <= wr_wen;
`endif
    end
  end

  assign head_line = line_reg[rd_idx];
  assign head_data = data_reg[rd_idx];
  assign head_wen  = wen_reg[rd_idx];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign ld_match[gi] = valid_reg[gi] && (line_reg[gi] == ld_line);
`ifdef STORE_BUF_MERGE_EN
      assign st_match[gi] = valid_reg[gi] && (line_reg[gi] == st_line);
`endif
    end
  endgenerate

endmodule

// File: rtl/u_lsu_store_buffer.sv
// ---------------------------------------------------------------------------
// u_lsu_store_buffer
// Posted-store queue between the LSU store path and data memory. Stores are
// queued in order and drained one per dmem_wr_ack; loads that touch a line
// with a pending store are flagged through ld_hazard.
//   clk, rst                 core clock, asynchronous active-high reset
//   st_valid/st_ready        store handshake (st_addr/st_data/st_wen payload)
//   ld_valid, ld_addr        load probe; ld_hazard = line pending in buffer
//   drain                    block new stores until the queue empties
//   buf_empty                no queued stores and no write in flight
//   dmem_wr_req/addr/data/wen, dmem_wr_ack   write port towards Dmem
// Optional feature: define STORE_BUF_MERGE_EN to merge a store into the
// youngest entry when both target the same line.
// ---------------------------------------------------------------------------
module u_lsu_store_buffer
  import u_lsu_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `DATA_MEM_WIDTH_BIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [`DATA_MEM_WIDTH-1:0] st_data,
  input  logic [`DATA_MEM_WIDTH-1:0] st_wen,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hazard,
  input  logic                       drain,
  output logic                       buf_empty,
  output logic                       dmem_wr_req,
  output logic [ADDR_W-1:0]          dmem_wr_addr,
  output logic [`DATA_MEM_WIDTH-1:0] dmem_wr_data,
  output logic [`DATA_MEM_WIDTH-1:0] dmem_wr_wen,
  input  logic                       dmem_wr_ack
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LINE_W = sb_line_w(ADDR_W);
  localparam int DATA_W = `DATA_MEM_WIDTH;

  sb_state_t         state_reg;
  logic              dmem_wr_req_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic              full;
  logic              merge_ok;
  logic              push;
  logic              alloc;
  logic              pop;
  logic [PTR_W-1:0]  wr_idx;
  logic [LINE_W-1:0] st_line;
  logic [LINE_W-1:0] ld_line;
  logic [LINE_W-1:0] head_line;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] head_wen;
  logic [DEPTH-1:0]  ld_match;
  logic              unused_offsets;

  assign st_line = st_addr[ADDR_W-1:LINE_OFFSET];
  assign ld_line = ld_addr[ADDR_W-1:LINE_OFFSET];
  assign unused_offsets = ^{st_addr[LINE_OFFSET-1:0], ld_addr[LINE_OFFSET-1:0]};

  assign full = (count_reg == CNT_W'(DEPTH));

`ifdef STORE_BUF_MERGE_EN
  logic [DEPTH-1:0] st_match;
  logic [PTR_W-1:0] young_idx;

  assign young_idx = wr_ptr_reg - 1'b1;
  // The head entry is frozen while it is being written to Dmem.
  assign merge_ok  = (count_reg != '0) && st_match[young_idx] &&
                     !((young_idx == rd_ptr_reg) && (state_reg == SB_ISSUE));
  assign wr_idx    = merge_ok ? young_idx : wr_ptr_reg;
`else
  assign merge_ok  = 1'b0;
  assign wr_idx    = wr_ptr_reg;
`endif

  // Ready comes from registered occupancy only, never from dmem_wr_ack.
  assign st_ready   = !drain && (!full || merge_ok);
  assign push       = st_valid && st_ready;
  assign alloc      = push && !merge_ok;
  assign pop        = dmem_wr_req_reg && dmem_wr_ack;
  assign count_next = count_reg + CNT_W'(alloc) - CNT_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= SB_IDLE;
      dmem_wr_req_reg <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      count_reg <= count_next;
      if (alloc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case (state_reg)
        SB_IDLE: begin
          if (count_reg != '0) begin
            state_reg       <= SB_ISSUE;
            dmem_wr_req_reg <= 1'b1;
          end
        end
        SB_ISSUE: begin
          // Stay in ISSUE for back-to-back writes while entries remain.
          if (pop && (count_next == '0)) begin
            state_reg       <= SB_IDLE;
            dmem_wr_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= SB_IDLE;
          dmem_wr_req_reg <= 1'b0;
        end
      endcase
    end
  end

  u_lsu_store_buffer_mem #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .LINE_W (LINE_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push),
    .wr_idx    (wr_idx),
    .wr_line   (st_line),
    .wr_data   (st_data),
    .wr_wen    (st_wen),
`ifdef STORE_BUF_MERGE_EN
    .wr_merge  (merge_ok),
    .st_line   (st_line),
    .st_match  (st_match),
`endif
    .clr_en    (pop),
    .clr_idx   (rd_ptr_reg),
    .rd_idx    (rd_ptr_reg),
    .head_line (head_line),
    .head_data (head_data),
    .head_wen  (head_wen),
    .ld_line   (ld_line),
    .ld_match  (ld_match)
  );

  // Head entry is only presented while a write is requested; zero otherwise.
  assign dmem_wr_req  = dmem_wr_req_reg;
  assign dmem_wr_addr = dmem_wr_req_reg ? {head_line, {LINE_OFFSET{1'b0}}} : '0;
  assign dmem_wr_data = dmem_wr_req_reg ? head_data : '0;
  assign dmem_wr_wen  = dmem_wr_req_reg ? head_wen  : '0;

  assign ld_hazard = ld_valid && (|ld_match);
  assign buf_empty = (count_reg == '0) && (state_reg == SB_IDLE);

endmodule

// File: tb/tb_u_lsu_store_buffer.sv
module tb_u_lsu_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic          clk;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [127:0]  st_data;
  logic [127:0]  st_wen;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;
  logic          drain;
  logic          buf_empty;
  logic          dmem_wr_req;
  logic [AW-1:0] dmem_wr_addr;
  logic [127:0]  dmem_wr_data;
  logic [127:0]  dmem_wr_wen;
  logic          dmem_wr_ack;

  u_lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_wen       (st_wen),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_hazard    (ld_hazard),
    .drain        (drain),
    .buf_empty    (buf_empty),
    .dmem_wr_req  (dmem_wr_req),
    .dmem_wr_addr (dmem_wr_addr),
    .dmem_wr_data (dmem_wr_data),
    .dmem_wr_wen  (dmem_wr_wen),
    .dmem_wr_ack  (dmem_wr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an ordered list of pending lines ----
  typedef struct {
    logic [11:0]  line;
    logic [127:0] data;
    logic [127:0] wen;
  } ent_t;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    logic [127:0] wen;
  } wr_t;

  ent_t mq[$];
  bit   m_busy = 1'b0;   // a Dmem write is being requested
  wr_t  wlog[$];         // writes observed as accepted by Dmem

  function automatic bit m_merge_legal();
`ifdef STORE_BUF_MERGE_EN
    if (mq.size() == 0) return 1'b0;
    return (mq[mq.size()-1].line == st_addr[15:4]) && !(mq.size() == 1 && m_busy);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return !drain && ((mq.size() < DEPTH) || m_merge_legal());
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    foreach (mq[i]) if (mq[i].line == a[15:4]) return 1'b1;
    return 1'b0;
  endfunction

  bit   m_pop, m_push, m_merge, m_nonempty;
  ent_t m_tmp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
    end else begin
      m_pop      = m_busy && (dmem_wr_ack === 1'b1);
      m_nonempty = (mq.size() != 0);
      m_push     = (st_valid === 1'b1) && m_ready();
      m_merge    = m_push && m_merge_legal();
      if (m_merge) begin
        m_tmp      = mq[mq.size()-1];
        m_tmp.data = (m_tmp.data & ~st_wen) | (st_data & st_wen);
        m_tmp.wen  = m_tmp.wen | st_wen;
        mq[mq.size()-1] = m_tmp;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_merge) begin
        m_tmp.line = st_addr[15:4];
        m_tmp.data = st_data;
        m_tmp.wen  = st_wen;
        mq.push_back(m_tmp);
      end
      if (!m_busy) m_busy = m_nonempty;
      else if (m_pop) m_busy = (mq.size() != 0);
    end
  end

  // ---------------- per-cycle compare against the model -------------------
  bit armed = 1'b0;
  always @(posedge clk) armed <= 1'b1;

  wr_t w_tmp;
  always @(negedge clk) begin
    if (armed) begin
      check("st_ready",  st_ready,    m_ready());
      check("ld_hazard", ld_hazard,   ld_valid && m_hit(ld_addr));
      check("buf_empty", buf_empty,   (mq.size() == 0) && !m_busy);
      check("wr_req",    dmem_wr_req, m_busy);
      if (m_busy && mq.size() != 0) begin
        check("wr_addr", dmem_wr_addr, {mq[0].line, 4'h0});
        check("wr_data", dmem_wr_data, mq[0].data);
        check("wr_wen",  dmem_wr_wen,  mq[0].wen);
      end
      if (rst) begin
        check("rst_addr", dmem_wr_addr, '0);
        check("rst_data", dmem_wr_data, '0);
        check("rst_wen",  dmem_wr_wen,  '0);
      end
      if (!rst && dmem_wr_req === 1'b1 && dmem_wr_ack === 1'b1) begin
        w_tmp.addr = dmem_wr_addr;
        w_tmp.data = dmem_wr_data;
        w_tmp.wen  = dmem_wr_wen;
        wlog.push_back(w_tmp);
        $display("write addr=%h wen=%h data=%h", dmem_wr_addr, dmem_wr_wen, dmem_wr_data);
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [127:0] d, input logic [127:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_wen   = w;
    step();
    st_valid = 1'b0;
    $display("push addr=%h wen=%h data=%h", a, w, d);
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (buf_empty !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check("drain_done", buf_empty, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int base;
  logic [15:0] ea;

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_wen = '0;
    ld_valid = 1'b0; ld_addr = '0; drain = 1'b0; dmem_wr_ack = 1'b0;
    step(); step();
    check("reset_ready", st_ready,    1'b1);
    check("reset_empty", buf_empty,   1'b1);
    check("reset_req",   dmem_wr_req, 1'b0);
    check("reset_haz",   ld_hazard,   1'b0);
    rst = 1'b0;
    step();

    // 1: single word store, req one cycle after push, addr line-aligned
    push(16'h0024, 128'h0000_0000_1234_5678_0000_0000_0000_0000,
                   128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000);
    check("t1_req_lat0", dmem_wr_req, 1'b0);
    step();
    check("t1_req_lat1", dmem_wr_req, 1'b1);
    check("t1_addr", dmem_wr_addr, 16'h0020);
    dmem_wr_ack = 1'b1;
    step();
    dmem_wr_ack = 1'b0;
    check("t1_empty", buf_empty, 1'b1);
    check("t1_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      check("t1_wr_addr", wlog[0].addr, 16'h0020);
      check("t1_wr_wen",  wlog[0].wen,  128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000);
    end
    // stray ack while idle must be ignored
    dmem_wr_ack = 1'b1;
    step();
    dmem_wr_ack = 1'b0;
    check("t1_stray_ack", wlog.size(), 1);

    // 2: fill, single pop, ordering
    base = wlog.size();
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i * 16), 128'(i + 1), 128'hFF);
    check("t2_full_ready", st_ready, 1'b0);
    dmem_wr_ack = 1'b1;
    step();
    dmem_wr_ack = 1'b0;
    check("t2_one_pop", wlog.size(), base + 1);
    check("t2_ready_after_pop", st_ready, 1'b1);
    dmem_wr_ack = 1'b1;
    wait_empty(20);
    dmem_wr_ack = 1'b0;
    check("t2_nwr", wlog.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      ea = 16'h0100 + 16'(i * 16);
      if (wlog.size() > base + i) check("t2_order", wlog[base + i].addr, ea);
    end

    // 3: load hazard
    push(16'h0040, 128'h55, 128'hFF);
    ld_valid = 1'b1; ld_addr = 16'h004C;
    #1 check("t3_haz_hit", ld_hazard, 1'b1);
    ld_addr = 16'h0050;
    #1 check("t3_haz_miss", ld_hazard, 1'b0);
    ld_valid = 1'b0;
    step();
    dmem_wr_ack = 1'b1;
    step();
    dmem_wr_ack = 1'b0;
    ld_valid = 1'b1; ld_addr = 16'h004C;
    #1 check("t3_haz_cleared", ld_hazard, 1'b0);
    ld_valid = 1'b0;
    step();

    // 4: reset during a write
    for (int i = 0; i < 3; i++) push(16'h0300 + 16'(i * 16), 128'hA0 + 128'(i), 128'hFF);
    check("t4_req", dmem_wr_req, 1'b1);
    base = wlog.size();
    #2 rst = 1'b1;
    #1 check("t4_req_drop", dmem_wr_req, 1'b0);
    check("t4_empty", buf_empty, 1'b1);
    check("t4_data0", dmem_wr_data, '0);
    step(); step();
    rst = 1'b0;
    dmem_wr_ack = 1'b1;
    repeat (5) step();
    dmem_wr_ack = 1'b0;
    check("t4_no_writes", wlog.size(), base);

    // 5: drain
    push(16'h0500, 128'h1, 128'hF);
    push(16'h0510, 128'h2, 128'hF);
    drain = 1'b1;
    #1 check("t5_drain_ready", st_ready, 1'b0);
    base = wlog.size();
    st_valid = 1'b1; st_addr = 16'h0520; st_data = 128'h3; st_wen = 128'hF;
    step();
    st_valid = 1'b0;
    dmem_wr_ack = 1'b1;
    wait_empty(20);
    dmem_wr_ack = 1'b0;
    check("t5_nwr", wlog.size(), base + 2);
    drain = 1'b0;
    #1 check("t5_ready_back", st_ready, 1'b1);
    step();

    // 6: same-line byte stores
    base = wlog.size();
    push(16'h0010, 128'hAA, 128'hFF);
    push(16'h0011, 128'hBB00, 128'hFF00);
    step();
`ifdef STORE_BUF_MERGE_EN
    check("t6_head_data", dmem_wr_data, 128'hBBAA);
    check("t6_head_wen",  dmem_wr_wen,  128'hFFFF);
`else
    check("t6_head_data", dmem_wr_data, 128'hAA);
    check("t6_head_wen",  dmem_wr_wen,  128'hFF);
`endif
    dmem_wr_ack = 1'b1;
    wait_empty(20);
    dmem_wr_ack = 1'b0;
`ifdef STORE_BUF_MERGE_EN
    check("t6_nwr", wlog.size(), base + 1);
`else
    check("t6_nwr", wlog.size(), base + 2);
`endif
    // same line, but the only entry is already in flight: must allocate
    base = wlog.size();
    push(16'h0200, 128'h11, 128'hFF);
    step(); step();
    push(16'h0204, 128'h2200_0000, 128'hFF00_0000);
    dmem_wr_ack = 1'b1;
    wait_empty(20);
    dmem_wr_ack = 1'b0;
    check("t6_inflight_nwr", wlog.size(), base + 2);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
